// File: rtl/window_watchdog_controller.sv
// Windowed watchdog: a closed first window (service = early fault), then an open second window (service required).
// Latency: state, WDRST and status are registered; decisions land on the CLK edge that sees the input edge or tick.
// No backpressure: INIT low forces IDLE on the next edge; RST clears everything asynchronously.
module window_watchdog_controller #(
    parameter int PRESCALE   = 1000,
    parameter int MAX_FAULTS = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       INIT,
    input  logic [7:0] FWLEN,
    input  logic [7:0] SWLEN,
    input  logic [7:0] RST_LMT,
    input  logic       WDSRVC,
    output logic       WDRST,
    output logic [2:0] FLSTAT,
    output logic [1:0] STATE,
    output logic [3:0] FLTCNT
);

    localparam int            PW          = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST  = PW'(PRESCALE - 1);
    localparam logic [3:0]    FAULT_LIMIT = 4'(MAX_FAULTS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_FIRST  = 2'b01,
        S_SECOND = 2'b10,
        S_RESET  = 2'b11
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [7:0]    tcnt;
    logic          init_q;
    logic          srv_q;
    logic          wdrst;
    logic [2:0]    flstat;
    logic [3:0]    fltcnt;

    logic          init_rise;
    logic          srv_rise;
    logic          tick;
    logic          expire;
    state_t        run_state;
    logic [7:0]    run_len;
    logic [7:0]    swlen_eff;
    logic [7:0]    rlmt_eff;
    logic [3:0]    fltcnt_inc;

    // Edge detects, tick/expiry strobes and the entry target for a fresh FIRST/SECOND cycle.
    always_comb begin
        init_rise  = INIT & ~init_q;
        srv_rise   = WDSRVC & ~srv_q;
        tick       = (state != S_IDLE) && (presc == PRESC_LAST);
        expire     = tick && (tcnt == 8'd1);
        swlen_eff  = (SWLEN == 8'd0) ? 8'd1 : SWLEN;
        rlmt_eff   = (RST_LMT == 8'd0) ? 8'd1 : RST_LMT;
        run_state  = (FWLEN == 8'd0) ? S_SECOND : S_FIRST;
        run_len    = (FWLEN == 8'd0) ? swlen_eff : FWLEN;
        fltcnt_inc = (fltcnt < FAULT_LIMIT) ? fltcnt + 4'd1 : fltcnt;
    end

    // Watchdog sequencer: window timing, fault recording and the registered WDRST request.
    // init_q resets high so an INIT already asserted when reset lifts is not an enable edge;
    // a fresh 0->1 on INIT is always needed to start the watchdog.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= S_IDLE;
            presc  <= '0;
            tcnt   <= 8'd0;
            init_q <= 1'b1;
            srv_q  <= 1'b0;
            wdrst  <= 1'b0;
            flstat <= 3'b000;
            fltcnt <= 4'd0;
        end else begin
            init_q <= INIT;
            srv_q  <= WDSRVC;
            if (state == S_IDLE || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end
            if (tick) begin
                tcnt <= tcnt - 8'd1;
            end

            if (!INIT) begin
                state <= S_IDLE;
                wdrst <= 1'b0;
                presc <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (init_rise) begin
                            flstat <= 3'b000;
                            fltcnt <= 4'd0;
                            state  <= run_state;
                            tcnt   <= run_len;
                            presc  <= '0;
                        end
                    end
                    S_FIRST: begin
                        // Service inside the closed window wins over expiry on the same tick.
                        if (srv_rise) begin
                            flstat[0] <= 1'b1;
                            fltcnt    <= fltcnt_inc;
                            state     <= S_RESET;
                            tcnt      <= rlmt_eff;
                            presc     <= '0;
                            wdrst     <= 1'b1;
                        end else if (expire) begin
                            state <= S_SECOND;
                            tcnt  <= swlen_eff;
                            presc <= '0;
                        end
                    end
                    S_SECOND: begin
                        // Service on the final tick still counts as a valid service.
                        if (srv_rise) begin
                            state <= run_state;
                            tcnt  <= run_len;
                            presc <= '0;
                        end else if (expire) begin
                            flstat[1] <= 1'b1;
                            fltcnt    <= fltcnt_inc;
                            state     <= S_RESET;
                            tcnt      <= rlmt_eff;
                            presc     <= '0;
                            wdrst     <= 1'b1;
                        end
                    end
                    S_RESET: begin
                        if (expire) begin
                            wdrst <= 1'b0;
                            presc <= '0;
                            if (fltcnt >= FAULT_LIMIT) begin
                                flstat[2] <= 1'b1;
                                state     <= S_IDLE;
                            end else begin
                                state <= run_state;
                                tcnt  <= run_len;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        wdrst <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign WDRST  = wdrst;
    assign FLSTAT = flstat;
    assign STATE  = state;
    assign FLTCNT = fltcnt;

endmodule
